// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer block.
//   state_t  : sequencer FSM states
//   DIR_UP   : step direction constant for incrementing (1)
//   DIR_DOWN : step direction constant for decrementing (0)
package count_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/up_down_counter.sv
// Loadable up/down counter with modulo-2^BITS wrap.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, clears count to 0
//   load     : load load_val this edge (wins over en)
//   load_val : value loaded when load=1
//   en       : step by one this edge
//   dir      : DIR_UP increments, DIR_DOWN decrements
//   count    : current counter value
module up_down_counter
    import count_seq_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    input  logic            en,
    input  logic            dir,
    output logic [BITS-1:0] count
);

    logic [BITS-1:0] count_q;
    logic [BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            // Natural BITS-wide overflow gives the required wrap in both directions.
            count_d = (dir == DIR_UP) ? count_q + BITS'(1) : count_q - BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/count_sequencer.sv
// Run sequencer: loads a start value, steps it toward a latched target once
// every PRESCALE cycles, supports pause and abort, and pulses done for one
// cycle when the target is reached.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : begin a run (sampled in IDLE only)
//   dir       : step direction captured at start (1 = up, 0 = down)
//   start_val : initial count loaded at start
//   target    : terminal value captured at start
//   pause     : freezes stepping while high
//   abort     : cancels the run (priority over pause)
//   count     : current counter value
//   busy      : high whenever the FSM is not IDLE
//   done      : one-cycle pulse on run completion
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int BITS     = 4,
    parameter int PRESCALE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dir,
    input  logic [BITS-1:0] start_val,
    input  logic [BITS-1:0] target,
    input  logic            pause,
    input  logic            abort,
    output logic [BITS-1:0] count,
    output logic            busy,
    output logic            done
);

    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    state_t          state_q, state_d;
    logic [7:0]      presc_q, presc_d;
    logic            dir_q, dir_d;
    logic [BITS-1:0] target_q, target_d;

    logic            cnt_load;
    logic            cnt_en;
    logic [BITS-1:0] cnt_val;
    logic [BITS-1:0] step_val;

    // Value the counter will hold after a step; used to spot target arrival
    // on the same edge as the step itself.
    assign step_val = (dir_q == DIR_UP) ? cnt_val + BITS'(1) : cnt_val - BITS'(1);

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        dir_d    = dir_q;
        target_d = target_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    dir_d    = dir;
                    target_d = target;
                    presc_d  = '0;
                    state_d  = (start_val == target) ? ST_DONE : ST_RUN;
                end
            end
            // RUN and PAUSE share one decision: abort, then pause, then tick.
            // Releasing pause ticks on that same edge, so no cycle is lost.
            ST_RUN, ST_PAUSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                    if (presc_q == PRESC_LAST) begin
                        cnt_en  = 1'b1;
                        presc_d = '0;
                        if (step_val == target_q) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        presc_d = presc_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            dir_q    <= DIR_DOWN;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            dir_q    <= dir_d;
            target_q <= target_d;
        end
    end

    up_down_counter #(
        .BITS(BITS)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (start_val),
        .en       (cnt_en),
        .dir      (dir_q),
        .count    (cnt_val)
    );

    assign count = cnt_val;
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 4, counter width in bits.
REQ-002 SHALL have parameter PRESCALE, default 1, number of clk cycles per count step (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a run (sampled in IDLE only).
REQ-006 SHALL have port dir  input  1  step direction captured at start (1 = up, 0 = down).
REQ-007 SHALL have port start_val  input  BITS  initial count loaded at start.
REQ-008 SHALL have port target  input  BITS  terminal value captured at start.
REQ-009 SHALL have port pause  input  1  freezes stepping while high in RUN.
REQ-010 SHALL have port abort  input  1  cancels the run.
REQ-011 SHALL have port count  output  BITS  current counter value.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse on run completion.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-015 IDLE + start=1 SHALL, at the next edge, load count=start_val, latch dir and target, clear the prescaler, and enter RUN.
REQ-016 Start in IDLE with start_val==target SHALL enter DONE directly, with no step.
REQ-017 In RUN, the prescaler SHALL increment every cycle; when it reaches PRESCALE-1, the next edge SHALL step count by +1 (dir=1) or -1 (dir=0) and clear the prescaler.
REQ-018 Count arithmetic SHALL wrap modulo 2^BITS (all-ones+1 -> 0, 0-1 -> all-ones).
REQ-019 The step that makes count equal the latched target SHALL move the state to DONE on that same edge.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-021 RUN + pause=1 SHALL enter PAUSE with no step that edge; PAUSE SHALL hold count and prescaler; pause=0 SHALL return to RUN.
REQ-022 abort=1 in RUN or PAUSE SHALL enter IDLE at the next edge, with count held, no step, and done never asserted.
REQ-023 Same-cycle priority SHALL be abort > pause > step.
REQ-024 start SHALL be ignored outside IDLE; the latched dir and target SHALL not change during a run.
REQ-025 count SHALL hold its value in IDLE between runs.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, count=0, prescaler=0, busy=0, done=0, and latched dir/target=0, regardless of clk.
REQ-027 Reset asserted mid-run SHALL abandon the run with no done pulse; after release, the block SHALL accept start normally.

Structure
REQ-028 A shared package count_seq_pkg SHALL hold the state enumeration and the direction constants DIR_UP=1 and DIR_DOWN=0.
REQ-029 Counting SHALL be done in one sub-module, up_down_counter (ports: clk, rst, load, load_val, en, dir, count), instantiated once.
REQ-030 The FSM and the prescaler SHALL reside in count_sequencer.

Verification (BITS=4, PRESCALE=1, start pulsed in cycle 0)
REQ-031 Up run, start_val=3, target=7, dir=1 -> count 3,4,5,6,7 in cycles 1-5; done=1 only in cycle 5; busy high in cycles 1-5; IDLE in cycle 6.
REQ-032 Up wrap, start_val=14, target=1, dir=1 -> count 14,15,0,1; done in the cycle count=1. Down wrap, start_val=1, target=14, dir=0 -> count 1,0,15,14.
REQ-033 Pause: with the start_val=3, target=7 run, pause=1 in cycles 2-3 -> count stays 4 through cycle 4; reaches 7 in cycle 7; done in cycle 7.
REQ-034 Abort: abort=1 in cycle 2 of the start_val=3, target=7 run -> IDLE in cycle 3; count=4 held; busy=0; done never high. A start in cycle 5 is accepted.
REQ-035 Async reset at cycle 2.5 of a run -> count=0 and busy=0 before the next edge; no done pulse.
REQ-036 Zero-length run, start_val=target=9 -> count=9 and done=1 in cycle 1; IDLE in cycle 2. A PRESCALE=3 variant of REQ-031 -> count steps every 3 cycles; done in cycle 13.
